// File: rtl/xbar_bypass_cfg_seq.sv
// Config sequencer for the bypass crossbar.
// Stores NUM_CTX crossbar configuration words and walks contexts 0..last
// while running. The decoded per-output one-hot selects and the register
// bypass vector for the current context are driven as registered outputs.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   i__cfg_wr_*          config table write (valid/ready, addr, data)
//   i__num_ctx_m1        last context of the loop, sampled on start
//   i__start/stop/stall  sequencing control
//   o__sel               per-output one-hot source select
//   o__regbypass         bit0 EAST, bit1 WEST, bit2 NORTH, bit3 SOUTH
//   o__ctx_idx           context currently driven on the outputs
//   o__running           sequencer in RUN
//   o__cfg_err           sticky illegal-field flag, cleared on start

// One output's 3-bit source field -> one-hot select. Codes >= NUM_IN
// (no-source and illegal) both decode to an empty select.
module xbar_src_dec #(
  parameter int NUM_IN = 6
) (
  input  logic [2:0]        fld,
  output logic [NUM_IN-1:0] sel
);
  localparam logic [2:0] NSRC = 3'(NUM_IN);
  assign sel = (fld < NSRC) ? (NUM_IN'(1) << fld) : '0;
endmodule

module xbar_bypass_cfg_seq #(
  parameter int NUM_CTX = 16,
  parameter int CTX_W   = 4,
  parameter int NUM_IN  = 6,
  parameter int NUM_OUT = 7,
  parameter int CFG_W   = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i__cfg_wr_valid,
  output logic              o__cfg_wr_ready,
  input  logic [CTX_W-1:0]  i__cfg_wr_addr,
  input  logic [CFG_W-1:0]  i__cfg_wr_data,
  input  logic [CTX_W-1:0]  i__num_ctx_m1,
  input  logic              i__start,
  input  logic              i__stop,
  input  logic              i__stall,
  output logic [NUM_IN-1:0] o__sel [NUM_OUT-1:0],
  output logic [3:0]        o__regbypass,
  output logic [CTX_W-1:0]  o__ctx_idx,
  output logic              o__running,
  output logic              o__cfg_err
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [CTX_W-1:0]  last;
  logic [CTX_W-1:0]  rd_idx;
  logic [CFG_W-1:0]  rd_word;
  logic              upd, clr, go, wr_fire, wr_bad;
  logic [NUM_IN-1:0] dec [NUM_OUT-1:0];

  logic [CFG_W-1:0]  tbl [NUM_CTX];

  assign o__cfg_wr_ready = (state == IDLE);
  assign o__running      = (state == RUN);
  assign wr_fire         = i__cfg_wr_valid && o__cfg_wr_ready;

  // Table has no reset so loaded configs survive a tile reset.
  always_ff @(posedge clk)
    if (wr_fire) tbl[i__cfg_wr_addr] <= i__cfg_wr_data;

  always_comb begin
    wr_bad = 1'b0;
    for (int i = 0; i < NUM_OUT; i++)
      if (i__cfg_wr_data[3*i +: 3] == 3'd6) wr_bad = 1'b1;
  end

  // Next state plus which context the registered outputs load from.
  always_comb begin
    state_nxt = state;
    upd       = 1'b0;
    clr       = 1'b0;
    go        = 1'b0;
    rd_idx    = (o__ctx_idx == last) ? '0 : o__ctx_idx + CTX_W'(1);
    case (state)
      IDLE: if (i__start && !i__stop) begin
        state_nxt = RUN;
        upd       = 1'b1;
        go        = 1'b1;
        rd_idx    = '0;
      end
      RUN: if (i__stop) begin
        state_nxt = IDLE;
        clr       = 1'b1;
      end else if (!i__stall) begin
        upd       = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_word = tbl[rd_idx];

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_dec
    xbar_src_dec #(.NUM_IN(NUM_IN)) u_dec (
      .fld (rd_word[3*g +: 3]),
      .sel (dec[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last         <= '0;
      o__ctx_idx   <= '0;
      o__regbypass <= '0;
      o__cfg_err   <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) o__sel[i] <= '0;
    end else begin
      state <= state_nxt;
      if (go) last <= i__num_ctx_m1;
      if (upd) begin
        o__ctx_idx   <= rd_idx;
        o__regbypass <= rd_word[CFG_W-1 -: 4];
        for (int i = 0; i < NUM_OUT; i++) o__sel[i] <= dec[i];
      end else if (clr) begin
        o__ctx_idx   <= '0;
        o__regbypass <= '0;
        for (int i = 0; i < NUM_OUT; i++) o__sel[i] <= '0;
      end
      // An illegal word written alongside a start still flags.
      if (wr_fire && wr_bad) o__cfg_err <= 1'b1;
      else if (go)           o__cfg_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_xbar_bypass_cfg_seq.sv
module tb_xbar_bypass_cfg_seq;
  logic        clk = 0, rst_n = 0;
  logic        wr_valid = 0, wr_ready;
  logic [3:0]  wr_addr = 0;
  logic [24:0] wr_data = 0;
  logic [3:0]  num_m1 = 0;
  logic        start = 0, stop = 0, stall = 0;
  logic [5:0]  sel [6:0];
  logic [3:0]  byp, ctx;
  logic        running, err;

  int npass = 0, ntot = 0;

  always #5 clk = ~clk;

  xbar_bypass_cfg_seq dut (
    .clk(clk), .rst_n(rst_n),
    .i__cfg_wr_valid(wr_valid), .o__cfg_wr_ready(wr_ready),
    .i__cfg_wr_addr(wr_addr), .i__cfg_wr_data(wr_data),
    .i__num_ctx_m1(num_m1), .i__start(start), .i__stop(stop), .i__stall(stall),
    .o__sel(sel), .o__regbypass(byp), .o__ctx_idx(ctx),
    .o__running(running), .o__cfg_err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [24:0] d);
    wr_valid = 1; wr_addr = a; wr_data = d;
    cyc();
    wr_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1; cyc(); start = 0;
  endtask

  // All outputs no-source except output o, which gets field f.
  function automatic logic [24:0] mk(input int o, input logic [2:0] f, input logic [3:0] b);
    logic [24:0] w;
    w = {b, 21'h1FFFFF};
    w[3*o +: 3] = f;
    return w;
  endfunction

  initial begin
    logic [24:0] w;
    #12;
    chk("rst_sel0", sel[0], 0);
    chk("rst_byp", byp, 0);
    chk("rst_run", running, 0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_ctx", ctx, 0);
    chk("rst_err", err, 0);
    @(negedge clk); rst_n = 1;

    // reset mid-RUN, table retained
    wr(0, mk(0, 3'd2, 4'b0101));
    num_m1 = 0;
    pulse_start();
    chk("run_sel0", sel[0], 6'b000100);
    chk("run_byp", byp, 4'b0101);
    chk("run_on", running, 1);
    cyc();
    chk("last0_ctx", ctx, 0);
    chk("last0_sel0", sel[0], 6'b000100);
    #2 rst_n = 0;
    #1;
    chk("arst_sel0", sel[0], 0);
    chk("arst_byp", byp, 0);
    chk("arst_run", running, 0);
    @(negedge clk); rst_n = 1;
    pulse_start();
    chk("retain_sel0", sel[0], 6'b000100);
    chk("retain_byp", byp, 4'b0101);
    stop = 1; cyc(); stop = 0;

    // wrap-around with stall at ctx 1
    wr(0, mk(3, 3'd0, 0));
    wr(1, mk(3, 3'd4, 0));
    wr(2, mk(3, 3'd5, 0));
    num_m1 = 2;
    pulse_start();
    chk("wr_c0_ctx", ctx, 0);
    chk("wr_c0_sel3", sel[3], 6'b000001);
    chk("wr_c0_sel0", sel[0], 0);
    cyc();
    chk("wr_c1_ctx", ctx, 1);
    chk("wr_c1_sel3", sel[3], 6'b010000);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_ctx", ctx, 1);
      chk("stall_sel3", sel[3], 6'b010000);
    end
    stall = 0;
    cyc();
    chk("wr_c2_ctx", ctx, 2);
    chk("wr_c2_sel3", sel[3], 6'b100000);
    cyc();
    chk("wrap_ctx", ctx, 0);
    chk("wrap_sel3", sel[3], 6'b000001);

    // stop beats stall and start
    stop = 1; stall = 1; start = 1;
    cyc();
    stop = 0; stall = 0; start = 0;
    chk("stop_run", running, 0);
    chk("stop_sel3", sel[3], 0);
    chk("stop_byp", byp, 0);
    chk("stop_ready", wr_ready, 1);
    chk("stop_ctx", ctx, 0);

    // write held during RUN is only taken once back in IDLE
    pulse_start();
    wr_valid = 1; wr_addr = 0; wr_data = mk(3, 3'd1, 4'b1000);
    #1 chk("gate_ready", wr_ready, 0);
    cyc(); cyc(); cyc();
    chk("gate_ctx", ctx, 0);
    chk("gate_sel3", sel[3], 6'b000001);
    chk("gate_byp", byp, 0);
    stop = 1; cyc(); stop = 0;
    chk("gate_idle_ready", wr_ready, 1);
    cyc();
    wr_valid = 0;
    pulse_start();
    chk("gate_new_sel3", sel[3], 6'b000010);
    chk("gate_new_byp", byp, 4'b1000);
    stop = 1; cyc(); stop = 0;

    // illegal field
    w = mk(5, 3'd6, 0);
    w[14:12] = 3'd3;
    wr(3, w);
    chk("ill_err_set", err, 1);
    start = 1; stop = 1; cyc(); start = 0; stop = 0;
    chk("ss_idle_run", running, 0);
    chk("ss_idle_err", err, 1);
    num_m1 = 3;
    pulse_start();
    chk("ill_err_clr", err, 0);
    cyc(); cyc(); cyc();
    chk("ill_ctx", ctx, 3);
    chk("ill_sel5", sel[5], 0);
    chk("ill_sel4", sel[4], 6'b001000);
    cyc();
    chk("ill_wrap_ctx", ctx, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/xbar_bypass_cfg_seq.md
Name: xbar_bypass_cfg_seq

Overview:
- Control-side counterpart of the bypass crossbar. It stores a small table of per-context crossbar configurations, sequences through them at runtime, and drives the crossbar's per-output one-hot selects and 4-bit register-bypass vector.
- It decodes compact 3-bit port indices into the one-hot form the crossbar re-encodes internally.
- It sits in the PE tile between the config loader and the crossbar.

Parameters:
- NUM_CTX, 16, number of stored contexts.
- CTX_W, 4, context index width; equals clog2(NUM_CTX).
- NUM_IN, 6, crossbar input ports (EAST, SOUTH, WEST, NORTH, ALU_T, TREG = indices 0..5).
- NUM_OUT, 7, crossbar output ports.
- CFG_W, 25, config word width; equals 3*NUM_OUT + 4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i__cfg_wr_valid  in  1  config write request.
- o__cfg_wr_ready  out  1  write accepted when valid&&ready.
- i__cfg_wr_addr  in  CTX_W  target context.
- i__cfg_wr_data  in  CFG_W  config word.
- i__num_ctx_m1  in  CTX_W  last context index of the loop; sampled at start.
- i__start  in  1  pulse: begin sequencing from context 0.
- i__stop  in  1  pulse: return to IDLE.
- i__stall  in  1  hold the current context.
- o__sel  out  NUM_IN x NUM_OUT  per-output one-hot select, unpacked [NUM_OUT-1:0].
- o__regbypass  out  4  bit0 EAST, bit1 WEST, bit2 NORTH, bit3 SOUTH; 1 = local source.
- o__ctx_idx  out  CTX_W  context currently driven.
- o__running  out  1  state==RUN.
- o__cfg_err  out  1  sticky: invalid field written.

Behaviour:
- Config word layout:
  - bits [3i+2:3i] = encoded source for output i; 0..5 = input index, 7 = no source (all-zero one-hot), 6 = illegal.
  - bits [24:21] = regbypass.
- Reset (async, rst_n low):
  - state=IDLE, ctx_idx=0, latched last index=0.
  - o__sel all zeros, o__regbypass=0, o__cfg_err=0, o__running=0.
  - Config table has no reset; contents survive reset.
- FSM states: IDLE, RUN.
- o__cfg_wr_ready = (state==IDLE), combinational. Writes take effect at the clock edge where valid&&ready. Writes in RUN are not accepted; the source holds valid.
- cfg_err:
  - Set on an accepted write whose data has any field ==6. The word is still stored.
  - Field 6 decodes to all-zero one-hot.
  - Cleared only on an accepted start.
- IDLE -> RUN on i__start && !i__stop.
  - At that edge: ctx_idx<=0, last<=i__num_ctx_m1, outputs<=decode(table[0]).
  - One-cycle latency from start to valid outputs.
- RUN, each edge:
  - i__stop=1: ->IDLE; o__sel<=0, o__regbypass<=0, ctx_idx<=0. Stop wins over stall and start.
  - else i__stall=1: all outputs and ctx_idx hold.
  - else: nxt = (ctx_idx==last) ? 0 : ctx_idx+1; ctx_idx<=nxt; outputs<=decode(table[nxt]). Outputs always match o__ctx_idx.
- i__start in RUN is ignored.
- i__start with i__stop in IDLE: stay IDLE, cfg_err unchanged.
- last=0 is legal: context 0 repeats every cycle.
- The table read path is combinational from ctx/nxt; outputs are registered (no combinational path input->output except ready).
- Decode: o__sel[i] = (field<6) ? (1<<field) : 0. At most one bit is set per output.
- Write data valid while ready=0 has no effect on the table.

Test Plan:
- Reset mid-RUN:
  - Load ctx0 (out0 field=2, others 7, bypass 4'b0101), start.
  - Deassert rst_n during RUN -> immediately o__sel all 0, regbypass 0, running 0.
  - After release, start again -> o__sel[0]=6'b000100, regbypass=4'b0101 (table retained).
- Wrap-around:
  - Load ctx0..2 with out3 fields 0,4,5; num_ctx_m1=2; start, no stall.
  - -> o__sel[3] sequence 000001, 010000, 100000, 000001, ...
  - -> o__ctx_idx 0,1,2,0.
- Stall:
  - During the above, assert stall for 3 cycles at ctx 1 -> o__sel[3]=010000 and ctx_idx=1 held 3 cycles, then advances to 2.
- Stop precedence:
  - In RUN, assert stop+stall+start in one cycle -> next cycle IDLE, all outputs 0, ready=1.
- Write gating:
  - In RUN, hold cfg_wr_valid at addr 0 -> ready=0, table unchanged.
  - After stop, the write is accepted in the first IDLE cycle.
- Illegal field:
  - Write out5 field=6 -> cfg_err=1.
  - Run that context -> o__sel[5]=0.
  - Next start -> cfg_err=0.
